// File: rtl/radix4_bfly_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : radix4_bfly_feeder_pkg
// Description : Shared sizes, complex-word type and sequencer state encoding
//               for the radix-4 DIF FFT butterfly feeder.
// Contents    : N, LOG4N, AW, DW, BW, cplx_t, fsm_t
// Revision    : 1.0 - initial release
// ============================================================================
package radix4_bfly_feeder_pkg;

  localparam int N     = 1024;  // FFT length (power of 4)
  localparam int LOG4N = 5;     // radix-4 stages
  localparam int AW    = 10;    // log2(N)
  localparam int DW    = 64;    // complex word width
  localparam int BW    = 8;     // butterfly counter width (N/4 butterflies)

  // Complex sample, two's complement {re, im}
  typedef struct packed {
    logic signed [31:0] re;
    logic signed [31:0] im;
  } cplx_t;

  // Sequencer states
  typedef enum logic [1:0] {
    FSM_IDLE    = 2'd0,
    FSM_READ    = 2'd1,
    FSM_WAIT_WB = 2'd2,
    FSM_FIN     = 2'd3
  } fsm_t;

endpackage
`default_nettype wire

// File: rtl/radix4_bfly_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : radix4_bfly_feeder_if
// Description : Bus bundle between the feeder, the data RAM read port, the
//               twiddle ROM and the radix-4 butterfly.
// Ports       : rd_en/rd_addr/rd_data    data RAM read (1-cycle latency)
//               tw_addr1..3/tw_data1..3  twiddle ROM (1-cycle latency)
//               Y0..Y3, TF1..TF3, enable, state, bf_base  butterfly issue
// Modports    : master = feeder, slave = memories + butterfly side
// Revision    : 1.0 - initial release
// ============================================================================
interface radix4_bfly_feeder_if;
  import radix4_bfly_feeder_pkg::*;

  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] tw_addr1, tw_addr2, tw_addr3;
  logic [DW-1:0] tw_data1, tw_data2, tw_data3;
  logic [DW-1:0] Y0, Y1, Y2, Y3;
  logic [DW-1:0] TF1, TF2, TF3;
  logic          enable;
  logic [2:0]    state;
  logic [AW-1:0] bf_base;

  modport master (
    output rd_en, rd_addr, tw_addr1, tw_addr2, tw_addr3,
    output Y0, Y1, Y2, Y3, TF1, TF2, TF3, enable, state, bf_base,
    input  rd_data, tw_data1, tw_data2, tw_data3
  );

  modport slave (
    input  rd_en, rd_addr, tw_addr1, tw_addr2, tw_addr3,
    input  Y0, Y1, Y2, Y3, TF1, TF2, TF3, enable, state, bf_base,
    output rd_data, tw_data1, tw_data2, tw_data3
  );

endinterface
`default_nettype wire

// File: rtl/radix4_bfly_feeder_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : radix4_bfly_feeder_addr_gen
// Description : Stage (s), butterfly (b) and point (m) counters plus the
//               in-place DIF read and twiddle address arithmetic.
// Ports       : clk, nrst          clock / async active-low reset
//               clr                clear all counters
//               adv                one read issued: step m (and b on m=3)
//               next_stage         s+1, b=m=0
//               stage, m, base     current counter view
//               rd_addr            base + m*qtr
//               tw_addr1..3        m*k*4^s, m = 1..3
//               last_rd_of_stage   b=255 and m=3
//               last_stage         s = LOG4N-1
// Revision    : 1.0 - initial release
// ============================================================================
module radix4_bfly_feeder_addr_gen
  import radix4_bfly_feeder_pkg::*;
(
  input  logic          clk,
  input  logic          nrst,
  input  logic          clr,
  input  logic          adv,
  input  logic          next_stage,
  output logic [2:0]    stage,
  output logic [1:0]    m,
  output logic [AW-1:0] base,
  output logic [AW-1:0] rd_addr,
  output logic [AW-1:0] tw_addr1,
  output logic [AW-1:0] tw_addr2,
  output logic [AW-1:0] tw_addr3,
  output logic          last_rd_of_stage,
  output logic          last_stage
);

  logic [2:0]    r_s;
  logic [BW-1:0] r_b;
  logic [1:0]    r_m;

  logic [3:0]    w_sh;
  logic [BW-1:0] w_mask;
  logic [BW-1:0] w_k;
  logic [BW-1:0] w_gq;
  logic [AW-1:0] w_qtr;
  logic [AW-1:0] w_off;
  logic [AW-1:0] w_tw1;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_s <= '0;
      r_b <= '0;
      r_m <= '0;
    end else if (clr) begin
      r_s <= '0;
      r_b <= '0;
      r_m <= '0;
    end else if (next_stage) begin
      r_s <= r_s + 3'd1;
      r_b <= '0;
      r_m <= '0;
    end else if (adv) begin
      r_m <= r_m + 2'd1;
      if (r_m == 2'd3) r_b <= r_b + 8'd1;
    end
  end

  // qtr = 4^(4-s) is a power of two, so b/qtr and b%qtr reduce to masking:
  // k = b & (qtr-1), and g*qtr = b & ~(qtr-1). base = 4*(g*qtr) + k.
  always_comb begin
    w_sh   = {r_s, 1'b0};
    w_mask = 8'hFF >> w_sh;
    w_k    = r_b & w_mask;
    w_gq   = r_b & ~w_mask;
    base   = {w_gq, 2'b00} + {2'b00, w_k};
    w_qtr  = 10'd256 >> w_sh;
    case (r_m)
      2'd0:    w_off = '0;
      2'd1:    w_off = w_qtr;
      2'd2:    w_off = w_qtr << 1;
      default: w_off = w_qtr + (w_qtr << 1);
    endcase
    rd_addr = base + w_off;
    // k*4^s < 256 for every stage, so 3*k*4^s fits AW without wrap
    w_tw1    = {2'b00, w_k} << w_sh;
    tw_addr1 = w_tw1;
    tw_addr2 = w_tw1 << 1;
    tw_addr3 = w_tw1 + (w_tw1 << 1);
    last_rd_of_stage = (r_b == BW'(N / 4 - 1)) && (r_m == 2'd3);
    last_stage       = (r_s == 3'(LOG4N - 1));
    stage = r_s;
    m     = r_m;
  end

endmodule
`default_nettype wire

// File: rtl/radix4_bfly_feeder.sv
`default_nettype none
// ============================================================================
// Module      : radix4_bfly_feeder
// Description : Sequencer for the radix-4 butterfly of a 1024-point in-place
//               DIF FFT. Streams four reads per butterfly, fetches three
//               twiddles, gathers them and issues Y0..Y3/TF1..TF3 with a
//               one-cycle enable, stage by stage, waiting for writeback
//               between stages.
// Ports       : clk, nrst       clock / async active-low reset
//               start           begin a run (sampled in IDLE only)
//               wb_stage_done   writeback finished the current stage
//               busy, done      run status / end-of-run pulse
//               bus (master)    RAM, twiddle ROM and butterfly signals
// Revision    : 1.0 - initial release
// ============================================================================
module radix4_bfly_feeder
  import radix4_bfly_feeder_pkg::*;
(
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       start,
  input  logic                       wb_stage_done,
  output logic                       busy,
  output logic                       done,
  radix4_bfly_feeder_if.master       bus
);

  fsm_t          r_fsm, w_fsm_nxt;
  logic          w_rd_en, w_adv, w_clr, w_next_stage;
  logic [2:0]    w_stage;
  logic [1:0]    w_m;
  logic [AW-1:0] w_base;
  logic          w_last_rd, w_last_stage;

  // Read-return pipeline: tags the data arriving this cycle
  logic          r_rv;
  logic [1:0]    r_rm;
  logic [AW-1:0] r_rbase;
  logic [2:0]    r_rstage;

  cplx_t         r_g0, r_g1, r_g2, r_gt1, r_gt2, r_gt3;
  logic [DW-1:0] r_y0, r_y1, r_y2, r_y3, r_tf1, r_tf2, r_tf3;
  logic          r_enable;
  logic [2:0]    r_state;
  logic [AW-1:0] r_bf_base;

  radix4_bfly_feeder_addr_gen u_addr_gen (
    .clk              (clk),
    .nrst             (nrst),
    .clr              (w_clr),
    .adv              (w_adv),
    .next_stage       (w_next_stage),
    .stage            (w_stage),
    .m                (w_m),
    .base             (w_base),
    .rd_addr          (bus.rd_addr),
    .tw_addr1         (bus.tw_addr1),
    .tw_addr2         (bus.tw_addr2),
    .tw_addr3         (bus.tw_addr3),
    .last_rd_of_stage (w_last_rd),
    .last_stage       (w_last_stage)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_fsm <= FSM_IDLE;
    else       r_fsm <= w_fsm_nxt;
  end

  // FSM: next state. wb_stage_done is only looked at in WAIT_WB; a pulse
  // seen in READ is simply dropped.
  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      FSM_IDLE:    if (start) w_fsm_nxt = FSM_READ;
      FSM_READ:    if (w_last_rd) w_fsm_nxt = FSM_WAIT_WB;
      FSM_WAIT_WB: if (wb_stage_done) w_fsm_nxt = w_last_stage ? FSM_FIN : FSM_READ;
      FSM_FIN:     w_fsm_nxt = FSM_IDLE;
      default:     w_fsm_nxt = FSM_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_rd_en      = (r_fsm == FSM_READ);
    busy         = (r_fsm == FSM_READ) || (r_fsm == FSM_WAIT_WB);
    done         = (r_fsm == FSM_FIN);
    w_adv        = w_rd_en;
    w_clr        = (r_fsm == FSM_FIN);
    w_next_stage = (r_fsm == FSM_WAIT_WB) && wb_stage_done && !w_last_stage;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rv     <= 1'b0;
      r_rm     <= '0;
      r_rbase  <= '0;
      r_rstage <= '0;
    end else begin
      r_rv     <= w_rd_en;
      r_rm     <= w_m;
      r_rbase  <= w_base;
      r_rstage <= w_stage;
    end
  end

  // Gather and issue. Twiddles were addressed in the m=0 read cycle, so they
  // return alongside the m=0 data. The m=3 word goes straight to Y3.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_g0      <= '0;
      r_g1      <= '0;
      r_g2      <= '0;
      r_gt1     <= '0;
      r_gt2     <= '0;
      r_gt3     <= '0;
      r_y0      <= '0;
      r_y1      <= '0;
      r_y2      <= '0;
      r_y3      <= '0;
      r_tf1     <= '0;
      r_tf2     <= '0;
      r_tf3     <= '0;
      r_enable  <= 1'b0;
      r_state   <= '0;
      r_bf_base <= '0;
    end else begin
      r_enable <= 1'b0;
      if (r_rv) begin
        case (r_rm)
          2'd0: begin
            r_g0  <= cplx_t'(bus.rd_data);
            r_gt1 <= cplx_t'(bus.tw_data1);
            r_gt2 <= cplx_t'(bus.tw_data2);
            r_gt3 <= cplx_t'(bus.tw_data3);
          end
          2'd1: r_g1 <= cplx_t'(bus.rd_data);
          2'd2: r_g2 <= cplx_t'(bus.rd_data);
          default: begin
            r_y0      <= r_g0;
            r_y1      <= r_g1;
            r_y2      <= r_g2;
            r_y3      <= bus.rd_data;
            r_tf1     <= r_gt1;
            r_tf2     <= r_gt2;
            r_tf3     <= r_gt3;
            r_bf_base <= r_rbase;
            r_state   <= r_rstage;
            r_enable  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.rd_en   = w_rd_en;
  assign bus.Y0      = r_y0;
  assign bus.Y1      = r_y1;
  assign bus.Y2      = r_y2;
  assign bus.Y3      = r_y3;
  assign bus.TF1     = r_tf1;
  assign bus.TF2     = r_tf2;
  assign bus.TF3     = r_tf3;
  assign bus.enable  = r_enable;
  assign bus.state   = r_state;
  assign bus.bf_base = r_bf_base;

endmodule
`default_nettype wire

// File: tb/tb_radix4_bfly_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_radix4_bfly_feeder
// Description : Self-checking bench for radix4_bfly_feeder. Memory and ROM
//               models return words that encode their address, so every
//               issued Y/TF value identifies the address that produced it.
//               Expected butterflies go into a scoreboard queue; a monitor
//               pops one per enable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_radix4_bfly_feeder;
  import radix4_bfly_feeder_pkg::*;

  logic clk = 1'b0;
  logic nrst, start, wb_stage_done, busy, done;

  radix4_bfly_feeder_if bus ();

  radix4_bfly_feeder dut (
    .clk           (clk),
    .nrst          (nrst),
    .start         (start),
    .wb_stage_done (wb_stage_done),
    .busy          (busy),
    .done          (done),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          s;
    int          b;
    logic [9:0]  base;
    logic [63:0] y0, y1, y2, y3, tf1, tf2, tf3;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0, n_bad = 0;
  int   n_en = 0, n_done = 0;
  int   cyc = 0, last_en_cyc = -100;

  function automatic logic [63:0] mem_word(input int a);
    return {32'h1000_0000 + 32'(a), 32'h5A5A_0000 ^ 32'(a)};
  endfunction

  function automatic logic [63:0] tw_word(input int e);
    return {32'h7000_0000 + 32'(e), 32'hC000_0000 | 32'(e)};
  endfunction

  // RAM / ROM models, one-cycle read latency
  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.rd_data  <= mem_word(int'(bus.rd_addr));
    bus.tw_data1 <= tw_word(int'(bus.tw_addr1));
    bus.tw_data2 <= tw_word(int'(bus.tw_addr2));
    bus.tw_data3 <= tw_word(int'(bus.tw_addr3));
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Expected butterflies of a whole run, derived with plain div/mod
  task automatic push_run();
    exp_t e;
    int qtr, g, k, bs, w;
    for (int s = 0; s < 5; s++) begin
      for (int b = 0; b < 256; b++) begin
        qtr = 1024 >> (2 * (s + 1));
        g   = b / qtr;
        k   = b % qtr;
        bs  = 4 * g * qtr + k;
        w   = k * (1 << (2 * s));
        e.s = s; e.b = b; e.base = 10'(bs);
        e.y0 = mem_word(bs);           e.y1 = mem_word(bs + qtr);
        e.y2 = mem_word(bs + 2 * qtr); e.y3 = mem_word(bs + 3 * qtr);
        e.tf1 = tw_word(w); e.tf2 = tw_word(2 * w); e.tf3 = tw_word(3 * w);
        sb.push_back(e);
      end
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (done) n_done++;
    if (nrst && bus.enable) begin
      n_en++;
      n_vec++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL bfly_unexpected_enable base=%0d state=%0d", bus.bf_base, bus.state);
      end else begin
        e = sb.pop_front();
        if ({bus.Y0, bus.Y1, bus.Y2, bus.Y3, bus.TF1, bus.TF2, bus.TF3} !==
              {e.y0, e.y1, e.y2, e.y3, e.tf1, e.tf2, e.tf3} ||
            bus.bf_base !== e.base || bus.state !== 3'(e.s)) begin
          n_bad++;
          $display("FAIL bfly s=%0d b=%0d got base=%0d state=%0d y0=%h y3=%h tf1=%h tf3=%h exp base=%0d y0=%h y3=%h tf1=%h tf3=%h",
                   e.s, e.b, bus.bf_base, bus.state, bus.Y0, bus.Y3, bus.TF1, bus.TF3,
                   e.base, e.y0, e.y3, e.tf1, e.tf3);
        end
        if (e.b != 0) begin
          n_vec++;
          if (cyc - last_en_cyc != 4) begin
            n_bad++;
            $display("FAIL enable_gap s=%0d b=%0d got=%0d exp=4", e.s, e.b, cyc - last_en_cyc);
          end
        end
        last_en_cyc = cyc;
      end
    end
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_rd_en"},   64'(bus.rd_en), 64'd0);
    chk({tag, "_rd_addr"}, 64'(bus.rd_addr), 64'd0);
    chk({tag, "_tw_addr"}, 64'({bus.tw_addr1, bus.tw_addr2, bus.tw_addr3}), 64'd0);
    chk({tag, "_enable"},  64'(bus.enable), 64'd0);
    chk({tag, "_Y0"},      bus.Y0, 64'd0);
    chk({tag, "_Y3"},      bus.Y3, 64'd0);
    chk({tag, "_TF"},      bus.TF1 | bus.TF2 | bus.TF3, 64'd0);
    chk({tag, "_state"},   64'(bus.state), 64'd0);
    chk({tag, "_bf_base"}, 64'(bus.bf_base), 64'd0);
    chk({tag, "_busy"},    64'(busy), 64'd0);
    chk({tag, "_done"},    64'(done), 64'd0);
  endtask

  // Entered at the negedge of the first read cycle
  task automatic first_reads();
    logic [9:0] ea[6];
    ea[0] = 10'd0; ea[1] = 10'd256; ea[2] = 10'd512;
    ea[3] = 10'd768; ea[4] = 10'd1; ea[5] = 10'd257;
    chk("first_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("first_rd_en_%0d", i), 64'(bus.rd_en), 64'd1);
      chk($sformatf("first_rd_addr_%0d", i), 64'(bus.rd_addr), 64'(ea[i]));
      chk($sformatf("first_enable_%0d", i), 64'(bus.enable), (i == 5) ? 64'd1 : 64'd0);
    end
  endtask

  task automatic stage_end(input int s, input bit last);
    for (int k = 0; k < 1100; k++) begin
      @(negedge clk);
      if (!bus.rd_en) break;
    end
    chk($sformatf("wait_wb_entered_s%0d", s), 64'(bus.rd_en), 64'd0);
    chk($sformatf("wait_wb_busy_s%0d", s), 64'(busy), 64'd1);
    chk($sformatf("wait_wb_no_enable_s%0d", s), 64'(bus.enable), 64'd0);
    @(negedge clk);
    chk($sformatf("final_enable_s%0d", s), 64'(bus.enable), 64'd1);
    @(negedge clk);
    chk($sformatf("hold_wait_wb_a_s%0d", s), 64'(bus.rd_en), 64'd0);
    @(negedge clk);
    chk($sformatf("hold_wait_wb_b_s%0d", s), 64'(bus.rd_en), 64'd0);
    @(negedge clk);
    wb_stage_done = 1'b1;
    @(negedge clk);
    wb_stage_done = 1'b0;
    if (!last) begin
      chk($sformatf("next_stage_rd_en_s%0d", s), 64'(bus.rd_en), 64'd1);
      chk($sformatf("next_stage_rd_addr_s%0d", s), 64'(bus.rd_addr), 64'd0);
    end else begin
      chk("fin_done", 64'(done), 64'd1);
      chk("fin_busy", 64'(busy), 64'd0);
      @(negedge clk);
      chk("idle_done", 64'(done), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_rd_en", 64'(bus.rd_en), 64'd0);
      start = 1'b0;
      @(negedge clk);
      chk("stay_idle_busy", 64'(busy), 64'd0);
      chk("stay_idle_rd_en", 64'(bus.rd_en), 64'd0);
    end
  endtask

  task automatic do_run(input bit hold_start, input int abort_stage);
    sb.delete();
    push_run();
    n_en   = 0;
    n_done = 0;
    start  = 1'b1;
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    first_reads();
    for (int s = 0; s < 5; s++) begin
      if (s == 0) begin
        // writeback pulse while still reading: must leave no trace
        @(negedge clk);
        wb_stage_done = 1'b1;
        @(negedge clk);
        wb_stage_done = 1'b0;
        chk("rd_pulse_still_reading", 64'(bus.rd_en), 64'd1);
      end
      if (s == abort_stage) begin
        repeat (300) @(negedge clk);
        chk("pre_abort_busy", 64'(busy), 64'd1);
        #2;
        nrst = 1'b0;
        #1;
        reset_checks("abort");
        sb.delete();
        repeat (2) @(negedge clk);
        nrst  = 1'b1;
        start = 1'b0;
        return;
      end
      stage_end(s, s == 4);
    end
    chk("run_enable_count", 64'(n_en), 64'd1280);
    chk("run_done_count", 64'(n_done), 64'd1);
    chk("run_sb_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    nrst          = 1'b0;
    start         = 1'b0;
    wb_stage_done = 1'b0;
    repeat (3) @(negedge clk);
    reset_checks("por");
    nrst = 1'b1;
    @(negedge clk);
    do_run(1'b1, -1);   // start held high for the whole run
    do_run(1'b0, 2);    // reset in the middle of stage 2
    do_run(1'b0, -1);   // fresh run after reset
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
